// File: rtl/w5300_sram_pkg.sv
// Shared types and constants for the W5300 byte-wide SRAM bus engine and its
// upstream 16-bit register sequencer.
package w5300_sram_pkg;

  localparam int unsigned W5300_ADDR_W = 10;
  localparam int unsigned W5300_DATA_W = 8;

  // Default bus timing, in clock cycles.
  localparam int unsigned DEF_SETUP_CYC   = 1;
  localparam int unsigned DEF_STROBE_CYC  = 4;
  localparam int unsigned DEF_HOLD_CYC    = 1;
  localparam int unsigned DEF_RECOVER_CYC = 2;
  localparam int unsigned DEF_CNT_W       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRecover
  } sram_state_e;

  // Counter preload for a phase lasting cyc cycles; a zero-length phase maps to 0.
  function automatic int unsigned phase_load(input int unsigned cyc);
    return (cyc == 0) ? 0 : cyc - 1;
  endfunction

endpackage

// File: rtl/w5300_sram_phase_cnt.sv
// Loadable down-counter that times each bus phase. It stops at zero.
module w5300_sram_phase_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/w5300_sram_bus_ctrl.sv
// W5300 SRAM-style bus engine: one byte read or write per start request with
// programmable setup/strobe/hold/recovery timing. All outputs are registered.
// Optional macro W5300_SRAM_INT_EN adds the w5300_int_n input and irq output.
module w5300_sram_bus_ctrl
  import w5300_sram_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    operation,
  input  logic [W5300_ADDR_W-1:0] address,
  input  logic [W5300_DATA_W-1:0] wdata,
  output logic                    busy,
  output logic                    data_rdy,
  output logic [W5300_DATA_W-1:0] rdata,
  output logic                    wr_fin_n,
  output logic [W5300_ADDR_W-1:0] w5300_addr,
  output logic [W5300_DATA_W-1:0] w5300_data_o,
  output logic                    w5300_data_oe,
  input  logic [W5300_DATA_W-1:0] w5300_data_i,
  output logic                    w5300_cs_n,
  output logic                    w5300_rd_n,
  output logic                    w5300_wr_n
`ifdef W5300_SRAM_INT_EN
  ,
  input  logic                    w5300_int_n,
  output logic                    irq
`endif
);

  localparam logic [CNT_W-1:0] SetupLd   = CNT_W'(phase_load(SETUP_CYC));
  localparam logic [CNT_W-1:0] StrobeLd  = CNT_W'(phase_load(STROBE_CYC));
  localparam logic [CNT_W-1:0] HoldLd    = CNT_W'(phase_load(HOLD_CYC));
  localparam logic [CNT_W-1:0] RecoverLd = CNT_W'(phase_load(RECOVER_CYC));

  sram_state_e      state;
  logic             op_rd;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  w5300_sram_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // Preload the phase counter on every state entry that has a timed phase.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      StIdle: begin
        cnt_load     = start;
        cnt_load_val = SetupLd;
      end
      StSetup: begin
        cnt_load     = cnt_zero;
        cnt_load_val = StrobeLd;
      end
      StStrobe: begin
        cnt_load     = cnt_zero;
        cnt_load_val = HoldLd;
      end
      StHold: begin
        cnt_load     = cnt_zero && (RECOVER_CYC != 0);
        cnt_load_val = RecoverLd;
      end
      default: ;
    endcase
  end

  // Access FSM; pin and status outputs are set on the edge entering each phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      op_rd         <= 1'b0;
      busy          <= 1'b0;
      data_rdy      <= 1'b0;
      wr_fin_n      <= 1'b1;
      rdata         <= '0;
      w5300_addr    <= '0;
      w5300_data_o  <= '0;
      w5300_data_oe <= 1'b0;
      w5300_cs_n    <= 1'b1;
      w5300_rd_n    <= 1'b1;
      w5300_wr_n    <= 1'b1;
    end else begin
      data_rdy <= 1'b0;
      wr_fin_n <= 1'b1;
      case (state)
        StIdle: begin
          if (start) begin
            state      <= StSetup;
            op_rd      <= operation;
            w5300_addr <= address;
            busy       <= 1'b1;
            w5300_cs_n <= 1'b0;
            if (!operation) begin
              w5300_data_o  <= wdata;
              w5300_data_oe <= 1'b1;
            end
          end
        end
        StSetup: begin
          if (cnt_zero) begin
            state      <= StStrobe;
            w5300_rd_n <= ~op_rd;
            w5300_wr_n <= op_rd;
          end
        end
        StStrobe: begin
          if (cnt_zero) begin
            state      <= StHold;
            w5300_rd_n <= 1'b1;
            w5300_wr_n <= 1'b1;
            if (op_rd) begin
              rdata <= w5300_data_i;
            end
            data_rdy <= op_rd;
            wr_fin_n <= op_rd;
          end
        end
        StHold: begin
          if (cnt_zero) begin
            w5300_cs_n    <= 1'b1;
            w5300_data_oe <= 1'b0;
            if (RECOVER_CYC == 0) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              state <= StRecover;
            end
          end
        end
        StRecover: begin
          if (cnt_zero) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef W5300_SRAM_INT_EN
  logic int_meta;
  logic int_sync;

  // Two-flop synchronizer on the interrupt pin, then a registered active-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta <= 1'b1;
      int_sync <= 1'b1;
      irq      <= 1'b0;
    end else begin
      int_meta <= w5300_int_n;
      int_sync <= int_meta;
      irq      <= ~int_sync;
    end
  end
`endif

endmodule

// File: doc/w5300_sram_bus_ctrl.md
Name: w5300_sram_bus_ctrl

Overview:
Byte-wide SRAM-style bus engine that drives the W5300 external pins (address, data, CSn, RDn, WRn) with programmable setup, strobe, hold and recovery timing. It sits directly downstream of the 16-bit register sequencer. It accepts one 8-bit read or write per start request and reports busy, read-data-ready and write-finished back to that sequencer. Data-bus tristating happens at top level using data_oe.

Parameters:
SETUP_CYC, 1, cycles CSn low before RDn/WRn falls (legal range >=1)
STROBE_CYC, 4, cycles RDn/WRn held low (legal range >=1)
HOLD_CYC, 1, cycles CSn held low after strobe rises (legal range >=1)
RECOVER_CYC, 2, cycles CSn high before next access may begin (legal range >=0)
CNT_W, 4, phase counter width; every *_CYC value must be < 2**CNT_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  access request; sampled only in IDLE
operation  in  1  1 = read, 0 = write; latched with start
address  in  10  byte address; latched with start
wdata  in  8  write byte; latched with start
busy  out  1  high from the cycle after acceptance until return to IDLE
data_rdy  out  1  one-cycle pulse; rdata is valid
rdata  out  8  captured read byte; holds its value until the next read capture
wr_fin_n  out  1  active-low one-cycle pulse; write strobe is complete
w5300_addr  out  10  address pins
w5300_data_o  out  8  write data to pins
w5300_data_oe  out  1  data-bus output enable
w5300_data_i  in  8  read data from pins
w5300_cs_n  out  1  chip select, active low
w5300_rd_n  out  1  read strobe, active low
w5300_wr_n  out  1  write strobe, active low

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-access): state=IDLE; busy=0, data_rdy=0, wr_fin_n=1, rdata=0, w5300_addr=0, w5300_data_o=0, w5300_data_oe=0, w5300_cs_n=1, w5300_rd_n=1, w5300_wr_n=1.
- All outputs come from flops; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. The phase counter is loaded with (X_CYC-1) on entry to each state and decremented each cycle; the state exits when the counter reaches 0.
- IDLE: if start=1, latch operation/address/wdata and enter SETUP; busy=1 on the next cycle. A start asserted while busy=1 is ignored, not queued.
- SETUP: cs_n=0, addr driven. On a write, data_oe=1 and data_o=wdata. Next state is STROBE.
- STROBE: rd_n=0 (read) or wr_n=0 (write). On the final STROBE cycle edge, rdata <= w5300_data_i (read only). Next state is HOLD.
- HOLD: strobes=1, cs_n=0, data_oe stays 1 on a write. On the first HOLD cycle, data_rdy=1 for a read or wr_fin_n=0 for a write; busy stays 1. Next state is RECOVER, or IDLE if RECOVER_CYC=0.
- RECOVER: cs_n=1, data_oe=0. Next state is IDLE.
- Latency with defaults: start sampled at edge 0; busy is high for exactly 8 cycles (edges 1..8); cs_n is low for 6 cycles; the strobe is low for 4 cycles; data_rdy/wr_fin_n pulse at cycle 6. A new start may be accepted on the first IDLE cycle.
- data_rdy and wr_fin_n are never both active. No pulse is emitted for an aborted access.

Optional Feature:
Macro: W5300_SRAM_INT_EN
- Defined: add input w5300_int_n and output irq.
  - w5300_int_n passes through a two-flop synchronizer (reset to 1).
  - irq = registered level of the synchronized, inverted signal; irq resets to 0.
  - Latency from pin to irq is 3 cycles.
- Not defined: neither port exists and no logic is generated.

Decomposition:
- Package w5300_sram_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RECOVER);
  - default timing constants and CNT_W;
  - W5300_ADDR_W=10 and W5300_DATA_W=8, shared with the 16-bit sequencer.
- One sub-module, w5300_sram_phase_cnt: a loadable CNT_W down-counter with load, value and zero flag. The FSM stays in the top module.

Test Plan:
- Read, defaults: address=10'h208, w5300_data_i=8'hA5 during STROBE, start pulse -> busy high 8 cycles, rd_n low 4 cycles, cs_n low 6 cycles, data_rdy one-cycle pulse with rdata=8'hA5, wr_n never low.
- Write, defaults: address=10'h001, wdata=8'h3C -> w5300_data_o=8'h3C with oe=1 from SETUP through HOLD, wr_n low 4 cycles, a single wr_fin_n low pulse, data_rdy stays 0.
- Back-to-back: start held high continuously for two accesses -> second SETUP begins on the cycle after busy falls, with RECOVER cs_n-high gap of 2 cycles; start pulses during busy ignored.
- Reset mid-STROBE: deassert rst_n in the 2nd strobe cycle -> cs_n/rd_n=1, oe=0 immediately, no data_rdy, IDLE after release.
- Parameter corner: SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1, RECOVER_CYC=0 -> busy 3 cycles, strobe 1 cycle, correct capture of 8'h5A.
- W5300_SRAM_INT_EN: drive w5300_int_n low at cycle 10 -> irq=1 at cycle 13; return high -> irq=0 three cycles later.
